// File: rtl/tx_frame_pad_pkg.sv
// Shared state encodings and byte-enable helpers for the tx_frame_pad block.
package tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_PAD  = 2'd2,
      ST_IFG  = 2'd3
   } state_e;

   localparam logic [7:0] KEEP_ALL = 8'hFF;

   // Contiguous-low keeps count their width; malformed keeps count as a full
   // beat mid-frame and by popcount on the closing beat.
   function automatic logic [3:0] keep_bytes(input logic [7:0] keep, input logic last);
      logic [3:0] n;
      logic       contig;
      n      = 4'd0;
      contig = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (keep == 8'((9'd1 << i) - 9'd1)) begin
            contig = 1'b1;
            n      = 4'(i);
         end
      end
      if (!contig) begin
         if (!last) begin
            n = 4'd8;
         end else begin
            n = 4'd0;
            for (int i = 0; i < 8; i++) n = n + {3'd0, keep[i]};
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] bytes_keep(input logic [3:0] n);
      return 8'((9'd1 << n) - 9'd1);
   endfunction

   function automatic logic [63:0] keep_mask(input logic [7:0] keep);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{keep[i]}};
      return m;
   endfunction

endpackage

// File: rtl/tx_frame_pad_if.sv
// AXI4-Stream bundle used between the padding core and its output register slice.
interface tx_frame_pad_if #(
   parameter int DW = 64
);
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic            tvalid;
   logic            tlast;
   logic            tuser;
   logic            tready;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/tx_frame_pad_reg_slice.sv
// Single-stage AXI4-Stream register slice; loads whenever its output is empty or draining.
module axis_reg_slice #(
   parameter int DW = 64
) (
   input  logic           clk156,
   input  logic           resetn,
   tx_frame_pad_if.slave  s_if,
   tx_frame_pad_if.master m_if
);

   logic [DW-1:0]   tdata_q, tdata_d;
   logic [DW/8-1:0] tkeep_q, tkeep_d;
   logic            tvalid_q, tvalid_d;
   logic            tlast_q, tlast_d;
   logic            tuser_q, tuser_d;
   logic            load;

   assign load        = ~tvalid_q | m_if.tready;
   assign s_if.tready = load;

   always_comb begin
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      if (load) begin
         tdata_d  = s_if.tdata;
         tkeep_d  = s_if.tkeep;
         tvalid_d = s_if.tvalid;
         tlast_d  = s_if.tlast;
         tuser_d  = s_if.tuser;
      end
   end

   always_ff @(posedge clk156 or negedge resetn) begin
      if (!resetn) begin
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
      end else begin
         tdata_q  <= tdata_d;
         tkeep_q  <= tkeep_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
      end
   end

   assign m_if.tdata  = tdata_q;
   assign m_if.tkeep  = tkeep_q;
   assign m_if.tvalid = tvalid_q;
   assign m_if.tlast  = tlast_q;
   assign m_if.tuser  = tuser_q;

endmodule

// File: rtl/tx_frame_pad.sv
// Pads short TX frames with zero bytes up to MIN_FRAME_BYTES before the MAC.
// Define TX_FRAME_PAD_IFG_EN to insert IFG_CYCLES idle output cycles between frames.
module tx_frame_pad
   import tx_pkg::*;
#(
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int MIN_FRAME_BYTES = 60,
   parameter int IFG_CYCLES      = 2
) (
   input  logic                        clk156,
   input  logic                        resetn,
   input  logic [AXI_DATA_WIDTH-1:0]   s_tdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s_tkeep,
   input  logic                        s_tvalid,
   input  logic                        s_tlast,
   output logic                        s_tready,
   output logic [AXI_DATA_WIDTH-1:0]   m_tdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_tkeep,
   output logic                        m_tvalid,
   output logic                        m_tlast,
   output logic                        m_tuser,
   input  logic                        m_tready,
   output logic [15:0]                 pkts_padded,
   output logic [31:0]                 pkts_sent
);

   localparam logic [15:0] MIN_B = 16'(MIN_FRAME_BYTES);

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {13'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   tx_frame_pad_if #(.DW(AXI_DATA_WIDTH)) core_if ();
   tx_frame_pad_if #(.DW(AXI_DATA_WIDTH)) out_if ();

   axis_reg_slice #(.DW(AXI_DATA_WIDTH)) u_slice (
      .clk156 (clk156),
      .resetn (resetn),
      .s_if   (core_if),
      .m_if   (out_if)
   );

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d, total, rem;
   logic [15:0] pkts_padded_q, pkts_padded_d;
   logic [31:0] pkts_sent_q, pkts_sent_d;
   logic        adv;
   logic [63:0] c_data;
   logic [7:0]  c_keep;
   logic        c_valid, c_last, c_user;
`ifdef TX_FRAME_PAD_IFG_EN
   // The IDLE cycle that follows IFG supplies the final idle output cycle.
   localparam state_e     DONE_ST  = (IFG_CYCLES > 1) ? ST_IFG : ST_IDLE;
   localparam logic [7:0] IFG_LOAD = 8'((IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0);
   logic [7:0] ifg_q, ifg_d;
`else
   localparam state_e DONE_ST = ST_IDLE;
`endif

   assign adv   = core_if.tready;
   assign total = sat_add(cnt_q, keep_bytes(s_tkeep, s_tlast));
   assign rem   = MIN_B - cnt_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pkts_padded_d = pkts_padded_q;
      pkts_sent_d   = pkts_sent_q + 32'(out_if.tvalid & m_tready & out_if.tlast);
      c_data        = '0;
      c_keep        = '0;
      c_valid       = 1'b0;
      c_last        = 1'b0;
      c_user        = 1'b0;
`ifdef TX_FRAME_PAD_IFG_EN
      ifg_d         = (state_q == ST_IFG) ? ifg_q : IFG_LOAD;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (s_tvalid) state_d = ST_PASS;
         end
         ST_PASS: begin
            if (adv && s_tvalid) begin
               c_valid = 1'b1;
               if (s_tlast && total < MIN_B) begin
                  // Short frame: widen the closing beat to a full zero-filled word.
                  c_data  = s_tdata & keep_mask(s_tkeep);
                  c_keep  = KEEP_ALL;
                  cnt_d   = sat_add(cnt_q, 4'd8);
                  state_d = ST_PAD;
               end else begin
                  c_data = s_tdata;
                  c_keep = s_tkeep;
                  c_last = s_tlast;
                  cnt_d  = total;
                  if (s_tlast) state_d = DONE_ST;
               end
            end else if (adv) begin
               c_user = 1'b1;
            end
         end
         ST_PAD: begin
            if (adv) begin
               c_valid = 1'b1;
               if (rem <= 16'd8) begin
                  c_keep        = bytes_keep(rem[3:0]);
                  c_last        = 1'b1;
                  pkts_padded_d = pkts_padded_q + 16'd1;
                  state_d       = DONE_ST;
               end else begin
                  c_keep = KEEP_ALL;
                  cnt_d  = sat_add(cnt_q, 4'd8);
               end
            end
         end
`ifdef TX_FRAME_PAD_IFG_EN
         ST_IFG: begin
            if (adv) begin
               if (ifg_q == 8'd0) state_d = ST_IDLE;
               else               ifg_d   = ifg_q - 8'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk156 or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         pkts_padded_q <= '0;
         pkts_sent_q   <= '0;
`ifdef TX_FRAME_PAD_IFG_EN
         ifg_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pkts_padded_q <= pkts_padded_d;
         pkts_sent_q   <= pkts_sent_d;
`ifdef TX_FRAME_PAD_IFG_EN
         ifg_q         <= ifg_d;
`endif
      end
   end

   assign core_if.tdata  = c_data;
   assign core_if.tkeep  = c_keep;
   assign core_if.tvalid = c_valid;
   assign core_if.tlast  = c_last;
   assign core_if.tuser  = c_user;

   assign s_tready      = (state_q == ST_PASS) & adv;
   assign out_if.tready = m_tready;
   assign m_tdata       = out_if.tdata;
   assign m_tkeep       = out_if.tkeep;
   assign m_tvalid      = out_if.tvalid;
   assign m_tlast       = out_if.tlast;
   assign m_tuser       = out_if.tuser;
   assign pkts_padded   = pkts_padded_q;
   assign pkts_sent     = pkts_sent_q;

endmodule
